queue_controller: RTL
=====================

Name: queue_controller

Overview:
Sequencer that turns the byte-wide dual-port queue memory into a circular FIFO.
It owns write, commit and read pointers and drives the memory's write and read ports directly. It presents a valid/ready push interface and a valid/ready pop interface, with a 2-entry prefetch buffer that hides the memory's 1-cycle read latency. It sits between a byte producer (e.g. command decoder) and a byte consumer (e.g. renderer queue reader), one controller per memory instance.

Parameters:
SIZE_KB, 1, memory capacity in KiB; must match the attached memory. SIZE = SIZE_KB*1024.
ADDR_W, $clog2(SIZE), derived localparam: memory address width.
CNT_W, ADDR_W+1, derived localparam: pointer and level width, with an extra wrap bit.

Ports:
i_master_clk  in  1  single clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  synchronous queue clear
i_push_data  in  8  byte to enqueue
i_push_valid  in  1  producer offers byte
o_push_ready  out  1  controller accepts byte
o_pop_data  out  8  head byte
o_pop_valid  out  1  head byte available
i_pop_ready  in  1  consumer takes byte
o_level  out  CNT_W  bytes held: memory + in-flight + buffer
o_empty  out  1  o_level==0
o_full  out  1  memory occupancy == SIZE
o_mem_write_address  out  ADDR_W  to memory write address
o_mem_write_data  out  8  to memory write data
o_mem_write_request  out  1  to memory write request
i_mem_write_done  in  1  from memory write done
o_mem_read_address  out  ADDR_W  to memory read address
o_mem_read_request  out  1  to memory read request
i_mem_read_data  in  8  from memory read data
i_mem_read_data_valid  in  1  from memory read data valid

Behaviour:
- Registers:
  - wr_ptr, commit_ptr, rd_ptr (CNT_W each); memory address = ptr[ADDR_W-1:0]; wrap is natural modulo 2^CNT_W.
  - inflight (1 bit).
  - buf_cnt (0..2) and 2 buffer entries.
- Reset (i_reset=1) and flush (i_flush=1): next edge clears all pointers, inflight, buf_cnt and buffer data.
  - While either is high: o_push_ready=0, both memory requests are 0, and i_mem_write_done / i_mem_read_data_valid are ignored.
  - After reset: o_pop_valid=0, o_level=0, o_empty=1, o_full=0, o_pop_data=0, memory outputs 0.
  - Reset has priority over flush.
- Push:
  - occ = wr_ptr - rd_ptr; o_full = (occ==SIZE); o_push_ready = !o_full && !i_reset && !i_flush.
  - push_fire = i_push_valid && o_push_ready. Memory write outputs are combinational: request = push_fire, address = wr_ptr, data = i_push_data. wr_ptr increments on push_fire.
  - Push while full: no write, no pointer change, byte not lost (producer holds it).
- Commit: commit_ptr increments on each i_mem_write_done. Only committed bytes are read.
- Read issue:
  - rd_en = (commit_ptr != rd_ptr) && (buf_cnt + inflight - pop_fire < 2) && !i_reset && !i_flush.
  - Memory read outputs are combinational: request = rd_en, address = rd_ptr.
  - rd_ptr increments on rd_en; inflight <= rd_en.
- Return: on i_mem_read_data_valid, i_mem_read_data appends to the buffer tail. inflight must equal i_mem_read_data_valid (bench assertion).
- Pop:
  - o_pop_valid = buf_cnt!=0; o_pop_data = buffer head.
  - pop_fire = o_pop_valid && i_pop_ready removes the head.
  - Simultaneous append and pop: buf_cnt unchanged, order preserved.
  - The buffer never overflows, guaranteed by the rd_en credit rule.
- Latency: push accepted in cycle N, then done in N+1, commit at end of N+1, read issued in N+2, data valid in N+3, o_pop_valid in N+4.
- Throughput: sustained 1 byte/cycle both sides once primed.
- Level:
  - o_level = occ + inflight + buf_cnt, combinational from registers; max SIZE+2.
  - o_empty = (o_level==0).
- Wrap: address SIZE-1 is followed by 0; wrap bit distinguishes full from empty.

Decomposition:
- No shared package needed: ADDR_W/CNT_W are derived locally from SIZE_KB, which must be passed identically to controller and memory.
- One sub-module: queue_prefetch_buffer.
  - 2-entry synchronous FIFO with append/pop, count and head outputs.
  - Same clock; cleared by reset or flush.

Test Plan:
- Single byte: reset, push 0xA5 at cycle N -> write request at N with address 0; o_pop_valid rises at N+4 with data 0xA5; o_level goes 1 at N+1 and 0 after the pop.
- Streaming: push 0x00..0xFF back-to-back with i_pop_ready=1 -> 256 bytes out in order, 1/cycle after 4-cycle latency, buf_cnt never exceeds 2.
- Fill with i_pop_ready=0, SIZE_KB=1:
  - Push 1027 bytes -> o_full=1 and o_push_ready=0 once occ reaches 1024.
  - o_level reaches 1026 (two bytes prefetched to buffer); the 1027th byte is held by the producer.
  - One pop -> o_full clears only after the next read issue.
- Wrap: cycle 3000 bytes through with random valid/ready -> address sequence ...1023, 0, 1...; data integrity vs scoreboard.
- Flush mid-stream: flush while a read is in flight and buffer full -> next cycle o_level=0, o_pop_valid=0; a late valid/done is ignored; the next push 0x3C emerges first.
- Reset mid-operation: assert i_reset for 1 cycle during simultaneous push and pop -> all outputs at reset values; no memory request during the reset cycle.

Source files
------------

// File: rtl/queue_controller_pkg.sv
// -----------------------------------------------------------------------------
// queue_controller_pkg
// Shared types and constants for the queue controller and its prefetch buffer.
// Pointer and address widths are not defined here. They are derived from
// SIZE_KB inside each module, so the controller and the memory it drives
// always agree when both receive the same SIZE_KB.
// -----------------------------------------------------------------------------
package queue_controller_pkg;

  // Width of one queue element.
  localparam int BYTE_W = 8;

  // Number of entries in the prefetch buffer that hides the memory read
  // latency. The read-issue credit rule is written against this value.
  localparam int PREFETCH_DEPTH = 2;

  typedef logic [BYTE_W-1:0] byte_t;

  // Prefetch buffer occupancy (0..PREFETCH_DEPTH).
  typedef logic [1:0] buf_cnt_t;

endpackage : queue_controller_pkg

// File: rtl/queue_controller_if.sv
// -----------------------------------------------------------------------------
// queue_controller_if
// Byte stream with valid/ready flow control.
//   data  : byte offered by the source
//   valid : source offers data this cycle
//   ready : sink accepts data this cycle
// A byte transfers on a cycle where valid && ready are both high. A source
// that raises valid holds data stable until the transfer happens.
// Modports:
//   master : the source side (drives data/valid, observes ready)
//   slave  : the sink side   (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface queue_controller_if;
  import queue_controller_pkg::*;

  byte_t data;
  logic  valid;
  logic  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface : queue_controller_if

// File: rtl/queue_controller_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// queue_prefetch_buffer
// Two-entry synchronous FIFO that holds bytes already read out of the queue
// memory. It presents its head byte as a valid/ready stream.
// Ports:
//   i_master_clk  : clock, rising edge
//   i_clear       : synchronous clear (reset or flush), empties the buffer
//   i_append      : write i_append_data at the tail this cycle
//   i_append_data : byte returned from memory
//   pop_if        : master stream; valid = buffer not empty, data = head
//   o_count       : entries currently held (0..2)
// The controller never appends to a full buffer unless the same cycle also
// pops. Its read-issue credit rule guarantees this, so an append to a full
// buffer without a pop is simply dropped here.
// -----------------------------------------------------------------------------
module queue_prefetch_buffer
  import queue_controller_pkg::*;
(
  input  logic                      i_master_clk,
  input  logic                      i_clear,
  input  logic                      i_append,
  input  byte_t                     i_append_data,
  queue_controller_if.master        pop_if,
  output buf_cnt_t                  o_count
);

  byte_t    r_entry [PREFETCH_DEPTH];
  buf_cnt_t r_count;
  logic     w_pop;

  assign pop_if.valid = (r_count != 2'd0);
  assign pop_if.data  = r_entry[0];
  assign w_pop        = (r_count != 2'd0) && pop_if.ready;
  assign o_count      = r_count;

  // Entry 0 is always the head. Popping shifts entry 1 down, so the head
  // read is a plain register output with no muxing.
  always_ff @(posedge i_master_clk) begin
    if (i_clear) begin
      r_count    <= 2'd0;
      r_entry[0] <= '0;
      r_entry[1] <= '0;
    end else begin
      case ({i_append, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_entry[0] <= i_append_data;
          end else if (r_count == 2'd1) begin
            r_entry[1] <= i_append_data;
          end
          if (r_count != 2'd2) begin
            r_count <= r_count + 2'd1;
          end
        end
        2'b01: begin
          r_entry[0] <= r_entry[1];
          r_entry[1] <= '0;
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous append and pop: the count is unchanged and the new
          // byte lands directly behind whatever remains.
          if (r_count == 2'd1) begin
            r_entry[0] <= i_append_data;
          end else begin
            r_entry[0] <= r_entry[1];
            r_entry[1] <= i_append_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : queue_prefetch_buffer

// File: rtl/queue_controller.sv
// -----------------------------------------------------------------------------
// queue_controller
// Turns a byte-wide dual-port queue memory (1-cycle write-done, 1-cycle read
// latency) into a circular FIFO with valid/ready push and pop interfaces.
//
// Handshake semantics (push and pop): a byte moves on every cycle where the
// offering side's valid and the receiving side's ready are both high. The
// offering side holds its byte and keeps valid high until that happens. Ready
// may depend combinationally on registers and on reset/flush, but never on
// the other side's valid.
//
// Ports:
//   i_master_clk           clock, rising edge
//   i_reset                synchronous active-high reset (wins over flush)
//   i_flush                synchronous queue clear
//   i_push_data/valid      producer byte and offer
//   o_push_ready           controller accepts the byte
//   o_pop_data/valid       head byte and its availability
//   i_pop_ready            consumer takes the head byte
//   o_level                bytes held: memory + in-flight read + buffer
//   o_empty / o_full       level == 0 / memory occupancy == SIZE
//   o_mem_write_*          memory write port (combinational from push)
//   i_mem_write_done       memory finished one write (advances commit)
//   o_mem_read_*           memory read port (combinational from read issue)
//   i_mem_read_data(_valid) memory read return, one cycle after request
//
// Pointers carry one wrap bit above the address, so wr - rd == SIZE is full
// and wr == rd is empty. Only committed bytes (acknowledged by write-done)
// are read back.
// -----------------------------------------------------------------------------
module queue_controller
  import queue_controller_pkg::*;
#(
  parameter  int SIZE_KB = 1,
  localparam int SIZE    = SIZE_KB * 1024,
  localparam int ADDR_W  = $clog2(SIZE),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic              i_master_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  byte_t             i_push_data,
  input  logic              i_push_valid,
  output logic              o_push_ready,
  output byte_t             o_pop_data,
  output logic              o_pop_valid,
  input  logic              i_pop_ready,
  output logic [CNT_W-1:0]  o_level,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_mem_write_address,
  output byte_t             o_mem_write_data,
  output logic              o_mem_write_request,
  input  logic              i_mem_write_done,
  output logic [ADDR_W-1:0] o_mem_read_address,
  output logic              o_mem_read_request,
  input  byte_t             i_mem_read_data,
  input  logic              i_mem_read_data_valid
);

  localparam logic [CNT_W-1:0] SIZE_CNT = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_commit_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             r_inflight;

  logic             w_clear;
  logic [CNT_W-1:0] w_occ;
  logic             w_full;
  logic             w_push_fire;
  logic             w_pop_fire;
  logic [2:0]       w_credit;
  logic             w_rd_en;
  logic             w_append;
  buf_cnt_t         w_buf_cnt;

  queue_controller_if w_pop_if ();

  // Reset and flush clear exactly the same state, so reset taking priority
  // over flush needs no separate path.
  assign w_clear = i_reset | i_flush;

  // ---------------------------------------------------------------- push side
  assign w_occ        = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_occ == SIZE_CNT);
  assign o_full       = w_full;
  assign o_push_ready = !w_full && !w_clear;
  assign w_push_fire  = i_push_valid && o_push_ready;

  assign o_mem_write_request = w_push_fire;
  assign o_mem_write_address = r_wr_ptr[ADDR_W-1:0];
  // Data is gated so the write port reads as all-zero whenever it is idle.
  assign o_mem_write_data    = w_push_fire ? i_push_data : '0;

  // ---------------------------------------------------------------- read side
  assign w_pop_if.ready = i_pop_ready;
  assign w_pop_fire     = w_pop_if.valid && w_pop_if.ready;

  // Credit: slots the buffer will need for bytes already in it or on their
  // way, less the one leaving this cycle. A new read is issued only if its
  // return is guaranteed a free slot.
  assign w_credit = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop_fire};
  assign w_rd_en  = (r_commit_ptr != r_rd_ptr)
                 && (w_credit < 3'(PREFETCH_DEPTH))
                 && !w_clear;

  assign o_mem_read_request = w_rd_en;
  assign o_mem_read_address = r_rd_ptr[ADDR_W-1:0];

  // Returns that land during reset/flush belong to the discarded queue.
  assign w_append = i_mem_read_data_valid && !w_clear;

  queue_prefetch_buffer u_prefetch (
    .i_master_clk  (i_master_clk),
    .i_clear       (w_clear),
    .i_append      (w_append),
    .i_append_data (i_mem_read_data),
    .pop_if        (w_pop_if),
    .o_count       (w_buf_cnt)
  );

  assign o_pop_valid = w_pop_if.valid;
  assign o_pop_data  = w_pop_if.data;

  // ---------------------------------------------------------------- level
  assign o_level = w_occ
                 + {{(CNT_W-1){1'b0}}, r_inflight}
                 + {{(CNT_W-2){1'b0}}, w_buf_cnt};
  assign o_empty = (o_level == '0);

  // ---------------------------------------------------------------- pointers
  always_ff @(posedge i_master_clk) begin
    if (w_clear) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_inflight   <= 1'b0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + ONE_CNT;
      end
      if (i_mem_write_done) begin
        r_commit_ptr <= r_commit_ptr + ONE_CNT;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ONE_CNT;
      end
      // The memory returns read data exactly one cycle after the request.
      r_inflight <= w_rd_en;
    end
  end

endmodule : queue_controller
